crc_engine: RTL and testbench
=============================

Name: crc_engine

Overview:
- Parametrised CRC generator/checker; successor to the fixed serial CRC7 cell.
- Configurable polynomial, width, init value and input beat width (1..8 bits per clock).
- Accepts a framed bit stream over a valid/ready handshake and holds the result.
- Serialises the CRC MSB-first for appending to a command/data line, and flags zero residue for receive-side checking.

Parameters:
CRC_W, 7, CRC register width (3..16)
POLY, 7'h09, generator polynomial without the implicit x^CRC_W term (default x^7+x^3+1)
INIT, 0, CRC register value on reset, clr and every new frame
DIN_W, 1, bits per input beat, MSB first (1..8)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous abort; return to IDLE, crc<=INIT
in_valid  in  1  input beat valid
in_data  in  DIN_W  input beat; bit DIN_W-1 processed first
in_last  in  1  marks final beat of frame (qualified by in_valid&in_ready)
in_ready  out  1  engine accepts a beat this cycle
crc  out  CRC_W  CRC register
crc_valid  out  1  frame complete, crc final (level, HOLD state)
crc_zero  out  1  crc_valid && crc==0 (receive check passed)
shift_req  in  1  start serial output of crc (HOLD only)
out_bit  out  1  serial CRC bit, MSB first
out_valid  out  1  out_bit valid
out_done  out  1  one-cycle pulse with last serial bit
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, CALC, HOLD, SHIFT. Reset: IDLE, crc=INIT, shift reg=0, counter=0, in_ready=1, all other outputs 0.
- Per-bit update for each of DIN_W bits, MSB first: fb = d ^ c[CRC_W-1]; c = (c<<1) ^ (fb ? POLY : 0). A whole beat completes in one clock.
- Beat accepted = in_valid && in_ready. The crc register updates on the accepting edge.
- IDLE: in_ready=1. Accepted beat -> CALC, or -> HOLD if in_last.
- CALC: in_ready=1. Each accepted beat updates crc; accepted beat with in_last -> HOLD. No beat: crc holds.
- HOLD: in_ready=0, crc_valid=1, crc stable.
  - shift_req=1: copy crc to shift reg, counter=0, -> SHIFT.
  - Otherwise remain in HOLD until clr.
- SHIFT: in_ready=0, crc_valid=1, crc stable.
  - out_valid=1; out_bit = shift_reg[CRC_W-1]; shift left each cycle.
  - On cycle CRC_W: out_done=1, -> IDLE with crc<=INIT.
  - out_valid is 0 the cycle after out_done.
- Latency:
  - crc_valid rises one cycle after the in_last beat is accepted.
  - First out_bit appears one cycle after shift_req in HOLD.
  - Serial output lasts exactly CRC_W cycles.
- Priority: rst_n > clr > all else. clr in any state: next cycle IDLE, crc=INIT, out_valid=0, no out_done.
- shift_req outside HOLD is ignored. in_valid while in_ready=0 is ignored (no update, no stall state).
- in_last on a single-beat frame from IDLE is legal.
- rst_n low mid-frame or mid-shift: immediate return to reset values; no partial out_done.
- crc_zero is 0 whenever crc_valid=0.

Test Plan:
- DIN_W=1, default params: frame 0x40_00000000 (40 bits, in_last on bit 40) -> crc_valid next cycle, crc=7'h4A, crc_zero=0.
- HOLD from the 0x40_00000000 frame, pulse shift_req -> out_bit 1,0,0,1,0,1,0 on 7 consecutive cycles, out_done with 7th bit, then IDLE with crc=0.
- DIN_W=8: beats 0x48,0x00,0x00,0x01,0xAA -> crc=7'h43. Beats 0x51,0x00,0x00,0x00,0x00 -> crc=7'h2A.
- DIN_W=1 receive check: 40 bits of 0x40_00000000 followed by the 7 bits 1001010, in_last on the final bit -> crc=0, crc_zero=1. Flip one bit -> crc_zero=0.
- Handshake: drop in_valid for random cycles mid-frame -> same crc 7'h4A. in_valid asserted during HOLD -> crc unchanged.
- clr in CALC after 10 bits, and clr on 3rd SHIFT cycle -> IDLE next cycle, crc=INIT, out_valid=0, no out_done. rst_n low in SHIFT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/crc_engine.sv
// crc_engine: parametrised CRC generator/checker with serial MSB-first output.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   clr_i        synchronous abort back to IDLE with crc = INIT
//   in_valid_i   input beat valid
//   in_data_i    input beat, bit DIN_W-1 processed first
//   in_last_i    final beat of frame
//   in_ready_o   engine accepts a beat this cycle
//   crc_o        CRC register
//   crc_valid_o  frame complete, crc final
//   crc_zero_o   crc_valid_o with zero residue
//   shift_req_i  start serial output (HOLD only)
//   out_bit_o    serial CRC bit, MSB first
//   out_valid_o  out_bit_o valid
//   out_done_o   pulse coinciding with the last serial bit
//   busy_o       engine not idle
module crc_engine #(
  parameter int               CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'('h09),
  parameter logic [CRC_W-1:0] INIT  = '0,
  parameter int               DIN_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             in_valid_i,
  input  logic [DIN_W-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [CRC_W-1:0] crc_o,
  output logic             crc_valid_o,
  output logic             crc_zero_o,
  input  logic             shift_req_i,
  output logic             out_bit_o,
  output logic             out_valid_o,
  output logic             out_done_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(CRC_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, HOLD, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               crc_valid_q, crc_valid_d;
  logic               crc_zero_q, crc_zero_d;
  logic               out_valid_q, out_valid_d;
  logic               out_done_q, out_done_d;
  logic               busy_q, busy_d;
  logic               accept;

  // Applies DIN_W serial CRC steps (MSB of the beat first) in one clock.
  function automatic logic [CRC_W-1:0] crcStep(input logic [CRC_W-1:0] c,
                                               input logic [DIN_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = DIN_W - 1; i >= 0; i--) begin
      fb = d[i] ^ r[CRC_W-1];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  assign accept = in_valid_i && in_ready_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;

    if (clr_i) begin
      state_d = IDLE;
      crc_d   = INIT;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, CALC: begin
          if (accept) begin
            // IDLE always starts from INIT so a new frame never inherits state.
            crc_d   = crcStep((state_q == IDLE) ? INIT : crc_q, in_data_i);
            state_d = in_last_i ? HOLD : CALC;
          end
        end
        HOLD: begin
          if (shift_req_i) begin
            shift_d = crc_q;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shift_d = {shift_q[CRC_W-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            crc_d   = INIT;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they leave the flops clean.
    in_ready_d  = (state_d == IDLE) || (state_d == CALC);
    crc_valid_d = (state_d == HOLD) || (state_d == SHIFT);
    crc_zero_d  = crc_valid_d && (crc_d == '0);
    out_valid_d = (state_d == SHIFT);
    out_done_d  = (state_d == SHIFT) && (cnt_d == LAST_CNT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      shift_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      crc_valid_q <= 1'b0;
      crc_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      crc_valid_q <= crc_valid_d;
      crc_zero_q  <= crc_zero_d;
      out_valid_q <= out_valid_d;
      out_done_q  <= out_done_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign crc_o       = crc_q;
  assign crc_valid_o = crc_valid_q;
  assign crc_zero_o  = crc_zero_q;
  assign out_bit_o   = shift_q[CRC_W-1];
  assign out_valid_o = out_valid_q;
  assign out_done_o  = out_done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: scoreboarded bench driving a bit-serial (DIN_W=1) and a
// byte-wide (DIN_W=8) crc_engine against a polynomial-division reference.
module tb_crc_engine;

  typedef bit         bitQ[$];
  typedef logic [7:0] byteQ[$];

  localparam logic [6:0] POLY_V = 7'h09;

  logic       clk;
  logic       rstN;

  logic       valid1, last1, clr1, shift1;
  logic [0:0] data1;
  logic       ready1, crcValid1, crcZero1, outBit1, outValid1, outDone1, busy1;
  logic [6:0] crc1;

  logic       valid8, last8, clr8, shift8;
  logic [7:0] data8;
  logic       ready8, crcValid8, crcZero8, outBit8, outValid8, outDone8, busy8;
  logic [6:0] crc8;

  int checkCount;
  int errorCount;

  logic [6:0] crcExp1[$];
  logic [6:0] crcExp8[$];
  bit         bitExp1[$];
  bit         doneExp1[$];
  bit         bitExp8[$];
  bit         doneExp8[$];
  logic       prevValid1;
  logic       prevValid8;

  crc_engine #(.DIN_W(1)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .clr_i(clr1),
    .in_valid_i(valid1), .in_data_i(data1), .in_last_i(last1),
    .in_ready_o(ready1), .crc_o(crc1), .crc_valid_o(crcValid1),
    .crc_zero_o(crcZero1), .shift_req_i(shift1), .out_bit_o(outBit1),
    .out_valid_o(outValid1), .out_done_o(outDone1), .busy_o(busy1)
  );

  crc_engine #(.DIN_W(8)) dut8 (
    .clk_i(clk), .rst_ni(rstN), .clr_i(clr8),
    .in_valid_i(valid8), .in_data_i(data8), .in_last_i(last8),
    .in_ready_o(ready8), .crc_o(crc8), .crc_valid_o(crcValid8),
    .crc_zero_o(crcZero8), .shift_req_i(shift8), .out_bit_o(outBit8),
    .out_valid_o(outValid8), .out_done_o(outDone8), .busy_o(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC: remainder of message * x^7 divided by x^7 + POLY, by long division.
  function automatic logic [6:0] refCrc(input bitQ msg);
    bit         work[$];
    logic [7:0] gen;
    logic [6:0] r;
    work = msg;
    for (int i = 0; i < 7; i++) work.push_back(1'b0);
    gen = {1'b1, POLY_V};
    for (int i = 0; i + 7 < work.size(); i++) begin
      if (work[i]) begin
        for (int j = 0; j < 8; j++) work[i+j] = work[i+j] ^ gen[7-j];
      end
    end
    for (int j = 0; j < 7; j++) r[6-j] = work[work.size()-7+j];
    return r;
  endfunction

  function automatic bitQ buildMsg(input byteQ bytes);
    bitQ m;
    foreach (bytes[i]) begin
      for (int k = 7; k >= 0; k--) m.push_back(bytes[i][k]);
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Ready"}, ready1, 1);
    checkOutput({tag, "Crc"}, crc1, 0);
    checkOutput({tag, "CrcValid"}, crcValid1, 0);
    checkOutput({tag, "CrcZero"}, crcZero1, 0);
    checkOutput({tag, "OutBit"}, outBit1, 0);
    checkOutput({tag, "OutValid"}, outValid1, 0);
    checkOutput({tag, "OutDone"}, outDone1, 0);
    checkOutput({tag, "Busy"}, busy1, 0);
  endtask

  // Drives one frame and queues its expected CRC for the monitor.
  task automatic applyStimulus(input bit useWide, input bitQ msg, input bit gaps,
                               output logic [6:0] expCrc);
    int         beats;
    logic [7:0] beat;
    expCrc = refCrc(msg);
    if (useWide) crcExp8.push_back(expCrc);
    else         crcExp1.push_back(expCrc);
    beats = useWide ? msg.size() / 8 : msg.size();
    for (int b = 0; b < beats; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
      if (useWide) begin
        for (int k = 0; k < 8; k++) beat[7-k] = msg[8*b+k];
        valid8 = 1'b1; data8 = beat; last8 = (b == beats - 1);
      end else begin
        valid1 = 1'b1; data1 = msg[b]; last1 = (b == beats - 1);
      end
      @(posedge clk); #1;
      valid1 = 1'b0; last1 = 1'b0;
      valid8 = 1'b0; last8 = 1'b0;
    end
  endtask

  task automatic requestShift(input bit useWide, input logic [6:0] expCrc, input int nBits);
    for (int k = 0; k < nBits; k++) begin
      if (useWide) begin
        bitExp8.push_back(expCrc[6-k]); doneExp8.push_back(k == 6);
      end else begin
        bitExp1.push_back(expCrc[6-k]); doneExp1.push_back(k == 6);
      end
    end
    if (useWide) shift8 = 1'b1; else shift1 = 1'b1;
    @(posedge clk); #1;
    shift1 = 1'b0; shift8 = 1'b0;
  endtask

  task automatic clearDut(input bit useWide);
    if (useWide) clr8 = 1'b1; else clr1 = 1'b1;
    @(posedge clk); #1;
    clr1 = 1'b0; clr8 = 1'b0;
  endtask

  // Monitor for the bit-serial engine: frame results and serial bits.
  always @(negedge clk) begin
    if (crcValid1 && !prevValid1) begin
      if (crcExp1.size() == 0) checkOutput("dut1UnexpectedFrame", 1, 0);
      else begin
        checkOutput("dut1Crc", crc1, crcExp1[0]);
        checkOutput("dut1CrcZero", crcZero1, int'(crcExp1[0] == 7'd0));
        void'(crcExp1.pop_front());
      end
    end
    if (!crcValid1) checkOutput("dut1ZeroGated", crcZero1, 0);
    if (outValid1) begin
      if (bitExp1.size() == 0) checkOutput("dut1UnexpectedBit", 1, 0);
      else begin
        checkOutput("dut1OutBit", outBit1, bitExp1[0]);
        checkOutput("dut1OutDone", outDone1, doneExp1[0]);
        void'(bitExp1.pop_front());
        void'(doneExp1.pop_front());
      end
    end else begin
      checkOutput("dut1StrayDone", outDone1, 0);
    end
    prevValid1 <= crcValid1;
  end

  // Monitor for the byte-wide engine.
  always @(negedge clk) begin
    if (crcValid8 && !prevValid8) begin
      if (crcExp8.size() == 0) checkOutput("dut8UnexpectedFrame", 1, 0);
      else begin
        checkOutput("dut8Crc", crc8, crcExp8[0]);
        checkOutput("dut8CrcZero", crcZero8, int'(crcExp8[0] == 7'd0));
        void'(crcExp8.pop_front());
      end
    end
    if (!crcValid8) checkOutput("dut8ZeroGated", crcZero8, 0);
    if (outValid8) begin
      if (bitExp8.size() == 0) checkOutput("dut8UnexpectedBit", 1, 0);
      else begin
        checkOutput("dut8OutBit", outBit8, bitExp8[0]);
        checkOutput("dut8OutDone", outDone8, doneExp8[0]);
        void'(bitExp8.pop_front());
        void'(doneExp8.pop_front());
      end
    end else begin
      checkOutput("dut8StrayDone", outDone8, 0);
    end
    prevValid8 <= crcValid8;
  end

  initial begin
    byteQ       bytes;
    bitQ        msg;
    logic [6:0] exp;
    int         len;
    int         flipIdx;
    bit         wide;

    checkCount = 0; errorCount = 0;
    rstN = 1'b0;
    valid1 = 0; data1 = 0; last1 = 0; clr1 = 0; shift1 = 0;
    valid8 = 0; data8 = 0; last8 = 0; clr8 = 0; shift8 = 0;
    prevValid1 = 0; prevValid8 = 0;

    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    checkOutput("dut8ResetReady", ready8, 1);
    checkOutput("dut8ResetCrc", crc8, 0);
    rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] CMD0 frame, serial engine");
    bytes = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    msg = buildMsg(bytes);
    applyStimulus(1'b0, msg, 1'b0, exp);
    checkOutput("cmd0Valid", crcValid1, 1);
    checkOutput("cmd0Crc", crc1, 7'h4A);
    checkOutput("cmd0Zero", crcZero1, 0);
    checkOutput("cmd0HoldReady", ready1, 0);
    requestShift(1'b0, 7'h4A, 7);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("afterShiftCrc", crc1, 0);
    checkOutput("afterShiftBusy", busy1, 0);
    checkOutput("afterShiftOutValid", outValid1, 0);
    checkOutput("afterShiftReady", ready1, 1);

    $display("[TB] byte-wide frames");
    bytes = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};
    msg = buildMsg(bytes);
    applyStimulus(1'b1, msg, 1'b0, exp);
    checkOutput("cmd8Crc", crc8, 7'h43);
    requestShift(1'b1, exp, 7);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("wideAfterShiftCrc", crc8, 0);
    bytes = '{8'h51, 8'h00, 8'h00, 8'h00, 8'h00};
    msg = buildMsg(bytes);
    applyStimulus(1'b1, msg, 1'b1, exp);
    checkOutput("cmd17Crc", crc8, 7'h2A);
    clearDut(1'b1);
    checkOutput("wideClrCrc", crc8, 0);
    checkOutput("wideClrValid", crcValid8, 0);

    $display("[TB] receive-side residue check");
    bytes = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    msg = buildMsg(bytes);
    msg.push_back(1); msg.push_back(0); msg.push_back(0); msg.push_back(1);
    msg.push_back(0); msg.push_back(1); msg.push_back(0);
    applyStimulus(1'b0, msg, 1'b0, exp);
    checkOutput("residueCrc", crc1, 0);
    checkOutput("residueZero", crcZero1, 1);
    clearDut(1'b0);
    flipIdx = $urandom_range(0, 46);
    msg[flipIdx] = ~msg[flipIdx];
    applyStimulus(1'b0, msg, 1'b0, exp);
    checkOutput("flippedZero", crcZero1, 0);
    clearDut(1'b0);

    $display("[TB] handshake gaps and ignored beats in HOLD");
    bytes = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    msg = buildMsg(bytes);
    applyStimulus(1'b0, msg, 1'b1, exp);
    checkOutput("gapCrc", crc1, 7'h4A);
    repeat (3) begin
      valid1 = 1'b1; last1 = 1'b1; data1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    valid1 = 1'b0; last1 = 1'b0;
    checkOutput("holdIgnoreCrc", crc1, 7'h4A);
    checkOutput("holdIgnoreValid", crcValid1, 1);
    requestShift(1'b0, 7'h4A, 7);
    repeat (7) @(posedge clk);
    #1;

    $display("[TB] clr in CALC");
    repeat (10) begin
      valid1 = 1'b1; last1 = 1'b0; data1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    valid1 = 1'b0;
    checkOutput("calcBusy", busy1, 1);
    checkOutput("calcNotValid", crcValid1, 0);
    clearDut(1'b0);
    checkOutput("calcClrBusy", busy1, 0);
    checkOutput("calcClrCrc", crc1, 0);
    checkOutput("calcClrReady", ready1, 1);

    $display("[TB] clr on third shift cycle");
    msg.delete();
    repeat (20) msg.push_back(1'($urandom_range(0, 1)));
    applyStimulus(1'b0, msg, 1'b0, exp);
    requestShift(1'b0, exp, 3);
    repeat (2) @(posedge clk);
    #1;
    clearDut(1'b0);
    checkOutput("shiftClrOutValid", outValid1, 0);
    checkOutput("shiftClrOutDone", outDone1, 0);
    checkOutput("shiftClrCrc", crc1, 0);
    checkOutput("shiftClrBusy", busy1, 0);
    @(posedge clk); #1;

    $display("[TB] reset during shift");
    msg.delete();
    repeat (25) msg.push_back(1'($urandom_range(0, 1)));
    applyStimulus(1'b0, msg, 1'b0, exp);
    requestShift(1'b0, exp, 1);
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    checkResetState("midShiftReset");
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] random frames");
    for (int n = 0; n < 16; n++) begin
      wide = 1'($urandom_range(0, 1));
      len = wide ? 8 * $urandom_range(1, 6) : $urandom_range(1, 50);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(1'($urandom_range(0, 1)));
      applyStimulus(wide, msg, 1'($urandom_range(0, 1)), exp);
      if ($urandom_range(0, 1) == 1) begin
        requestShift(wide, exp, 7);
        repeat (7) @(posedge clk);
        #1;
      end else begin
        clearDut(wide);
      end
    end

    for (int c = 0; c < 20; c++) begin
      if (crcExp1.size() + crcExp8.size() + bitExp1.size() + bitExp8.size() == 0) break;
      @(posedge clk); #1;
    end
    checkOutput("queuesDrained",
                crcExp1.size() + crcExp8.size() + bitExp1.size() + bitExp8.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
